// File: rtl/layer1_fmap_buffer.sv
// ----------------------------------------------------------------------------
// layer1_fmap_buffer
//
// Sits after the layer-1 conv + 2x2 max-pool stage. Each input beat carries
// one pooled pixel for all six channels. Every sample is passed through ReLU
// and then requantised: a rounded right shift by SHIFT, saturated to 127. The
// result is written into a 6 x (FM_WIDTH*FM_HEIGHT) buffer. Once a full frame
// has been stored, the buffer is replayed to layer 2 over valid/ready. The
// replay order is channel-major and, within a channel, row-major.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   valid_in           input beat valid (no backpressure to upstream)
//   in_ch0..in_ch5     signed pooled samples, one per channel
//   out_ready          downstream accepts the current beat
//   out_valid          out_* fields hold a valid beat
//   out_data           requantised activation (always 0..127)
//   out_ch             channel of the current beat
//   out_idx            pixel index within the channel, row*FM_WIDTH+col
//   out_last           final beat of the frame (last channel, last pixel)
//   frame_done         one-cycle pulse after the last beat is accepted
//   overflow           sticky: an input beat arrived while draining and was
//                      dropped
// ----------------------------------------------------------------------------
module layer1_fmap_buffer #(
    parameter int unsigned FM_WIDTH  = 12,
    parameter int unsigned FM_HEIGHT = 12,
    parameter int unsigned NUM_CH    = 6,   // the port list fixes this at 6
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned SHIFT     = 8    // must be >= 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic signed [IN_WIDTH-1:0] in_ch0,
    input  logic signed [IN_WIDTH-1:0] in_ch1,
    input  logic signed [IN_WIDTH-1:0] in_ch2,
    input  logic signed [IN_WIDTH-1:0] in_ch3,
    input  logic signed [IN_WIDTH-1:0] in_ch4,
    input  logic signed [IN_WIDTH-1:0] in_ch5,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    output logic [2:0]                 out_ch,
    output logic [7:0]                 out_idx,
    output logic                       out_last,
    output logic                       frame_done,
    output logic                       overflow
);

    localparam int unsigned PIX   = FM_WIDTH * FM_HEIGHT;
    localparam int unsigned POS_W = 8;               // matches out_idx
    localparam int unsigned XW    = IN_WIDTH + 1;    // rounding headroom

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(PIX - 1);
    localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);
    localparam logic [XW-1:0]    ROUND    = XW'(1) << (SHIFT - 1);
    localparam logic [XW-1:0]    SAT_MAX  = XW'(127);

    // ------------------------------------------------------------------------
    // Requantisation: ReLU, round-half-up shift, saturate to int8.
    // The sum is one bit wider than the input, so the largest positive input
    // cannot wrap negative when the rounding constant is added.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] requant(input logic signed [IN_WIDTH-1:0] x);
        logic [XW-1:0] sum;
        logic [XW-1:0] y;
        if (x[IN_WIDTH-1]) begin
            return 8'd0;
        end
        sum = {1'b0, x} + ROUND;
        y   = sum >> SHIFT;
        if (y > SAT_MAX) begin
            return 8'd127;
        end
        return {1'b0, y[6:0]};
    endfunction

    logic signed [IN_WIDTH-1:0] in_arr [NUM_CH];
    logic [7:0]                 q_val  [NUM_CH];

    always_comb begin
        in_arr[0] = in_ch0;
        in_arr[1] = in_ch1;
        in_arr[2] = in_ch2;
        in_arr[3] = in_ch3;
        in_arr[4] = in_ch4;
        in_arr[5] = in_ch5;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            q_val[c] = requant(in_arr[c]);
        end
    end

    // ------------------------------------------------------------------------
    // FSM: FILL collects a frame, DRAIN replays it.
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e state_q, state_d;

    logic [POS_W-1:0] wr_pos_q, wr_pos_d;
    logic [2:0]       rd_ch_q, rd_ch_d;
    logic [POS_W-1:0] rd_pos_q, rd_pos_d;
    logic             primed_q, primed_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [2:0]       out_ch_q, out_ch_d;
    logic [7:0]       out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;

    logic             wr_en;
    logic             load;
    logic             accept_last;
    logic             drop;
    logic             rd_at_end;
    logic [7:0]       rd_data;

    logic [7:0]       mem_q [NUM_CH][PIX];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: begin
                if (valid_in && (wr_pos_q == LAST_POS)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (accept_last) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // FSM outputs (control strobes)
    always_comb begin
        wr_en       = 1'b0;
        load        = 1'b0;
        accept_last = 1'b0;
        drop        = 1'b0;
        unique case (state_q)
            StFill: begin
                wr_en = valid_in;
            end
            StDrain: begin
                drop        = valid_in;
                accept_last = out_valid_q && out_ready && out_last_q;
                // Fill the empty output register once after entry, then
                // refill it on every non-final acceptance so a sustained
                // out_ready streams one beat per cycle.
                load = (!out_valid_q && primed_q) ||
                       (out_valid_q && out_ready && !out_last_q);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Feature-map storage: one bank per channel, all written in one cycle.
    // The contents are don't-care after reset, so the banks have no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mem_q[c][wr_pos_q] <= q_val[c];
            end
        end
    end

    assign rd_data   = mem_q[rd_ch_q][rd_pos_q];
    assign rd_at_end = (rd_ch_q == LAST_CH) && (rd_pos_q == LAST_POS);

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        wr_pos_d     = wr_pos_q;
        rd_ch_d      = rd_ch_q;
        rd_pos_d     = rd_pos_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_idx_d    = out_idx_q;
        out_last_d   = out_last_q;
        frame_done_d = accept_last;
        overflow_d   = overflow_q | drop;

        // primed_q marks the cycle after DRAIN entry onward: that is the
        // first cycle in which the read of (0, 0) is issued.
        primed_d = (state_q == StDrain) && (state_d == StDrain);

        if (wr_en) begin
            wr_pos_d = (wr_pos_q == LAST_POS) ? '0 : wr_pos_q + POS_W'(1);
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data;
            out_ch_d    = rd_ch_q;
            out_idx_d   = rd_pos_q;
            out_last_d  = rd_at_end;
            // Advance the read address; wrapping after the final entry
            // leaves rd_ch/rd_pos at 0 for the next frame.
            if (rd_pos_q == LAST_POS) begin
                rd_pos_d = '0;
                rd_ch_d  = rd_at_end ? 3'd0 : rd_ch_q + 3'd1;
            end else begin
                rd_pos_d = rd_pos_q + POS_W'(1);
            end
        end else if (accept_last) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pos_q     <= '0;
            rd_ch_q      <= '0;
            rd_pos_q     <= '0;
            primed_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_pos_q     <= wr_pos_d;
            rd_ch_q      <= rd_ch_d;
            rd_pos_q     <= rd_pos_d;
            primed_q     <= primed_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_layer1_fmap_buffer.sv
// ----------------------------------------------------------------------------
// Bench for layer1_fmap_buffer. A reference feature map is computed from the
// stimulus with plain integer arithmetic. A compare process walks the
// expected replay order on every falling edge. Directed scenarios cover
// requantisation edge values, full frames, random backpressure, dropped
// input, reset during replay and gapped input.
// ----------------------------------------------------------------------------
module tb_layer1_fmap_buffer;

    localparam int SHIFT = 8;
    localparam int PIX   = 144;
    localparam int NBEAT = 864;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_v [6];
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic [7:0]  out_idx;
    logic        out_last;
    logic        frame_done;
    logic        overflow;

    always #5 clk = ~clk;

    layer1_fmap_buffer #(
        .FM_WIDTH (12),
        .FM_HEIGHT(12),
        .NUM_CH   (6),
        .IN_WIDTH (32),
        .SHIFT    (SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .in_ch0    (in_v[0]),
        .in_ch1    (in_v[1]),
        .in_ch2    (in_v[2]),
        .in_ch3    (in_v[3]),
        .in_ch4    (in_v[4]),
        .in_ch5    (in_v[5]),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int model_fm [6][PIX];
    int cap [NBEAT];
    int j = 0;
    int beats_total = 0;
    bit done_exp = 1'b0;
    bit rdy_mode = 1'b0;
    int rq0 [6] = '{383, 384, -5, 32639, 32640, 40000};
    int rq1 [4] = '{-1, 127, 128, 2147483647};

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference requantisation: ReLU, round half up, clamp to 127.
    function automatic int rq(input int x);
        longint t;
        if (x < 0) return 0;
        t = (longint'(x) + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (t > 127) return 127;
        return int'(t);
    endfunction

    // kind 0: standard ramp; kind 1: ramp with requantisation edge values
    function automatic int stim(input int kind, input int c, input int n);
        if (kind == 1 && c == 0 && n < 6) return rq0[n];
        if (kind == 1 && c == 1 && n < 4) return rq1[n];
        return ((c * PIX + n) % 128) << 8;
    endfunction

    // Ready driver: always ready, or roughly 2/3 ready at random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Compare process: checks every visible beat against the expected order.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                j = 0;
                done_exp = 1'b0;
            end else begin
                check("frame_done", frame_done, done_exp);
                done_exp = 1'b0;
                if (out_valid) begin
                    check($sformatf("out_data beat %0d", j), out_data, model_fm[j / PIX][j % PIX]);
                    check($sformatf("out_ch beat %0d", j), out_ch, j / PIX);
                    check($sformatf("out_idx beat %0d", j), out_idx, j % PIX);
                    check($sformatf("out_last beat %0d", j), out_last, (j == NBEAT - 1) ? 1 : 0);
                    if (out_ready) begin
                        cap[j] = out_data;
                        beats_total++;
                        if (j == NBEAT - 1) begin
                            j = 0;
                            done_exp = 1'b1;
                        end else begin
                            j++;
                        end
                    end
                end
            end
        end
    end

    task automatic drive_frame(input int kind, input bit gap);
        for (int n = 0; n < PIX; n++) begin
            for (int c = 0; c < 6; c++) begin
                in_v[c] = stim(kind, c, n);
                model_fm[c][n] = rq(stim(kind, c, n));
            end
            valid_in = 1'b1;
            @(posedge clk);
            #1;
            if (gap && n != PIX - 1) begin
                valid_in = 1'b0;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("out_valid 1 edge after last write", out_valid, 0);
        @(posedge clk);
        #1;
        check("out_valid 2 edges after last write", out_valid, 1);
    endtask

    task automatic wait_done(output int cycles);
        bit found;
        found = 1'b0;
        cycles = 0;
        while (!found && cycles < 4000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (frame_done) found = 1'b1;
        end
        if (!found) check("frame_done timeout", 0, 1);
    endtask

    task automatic wait_beats(input int target);
        int cyc;
        cyc = 0;
        while (beats_total < target && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (beats_total < target) check("beat count timeout", beats_total, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_data"}, out_data, 0);
        check({tag, " out_ch"}, out_ch, 0);
        check({tag, " out_idx"}, out_idx, 0);
        check({tag, " out_last"}, out_last, 0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " overflow"}, overflow, 0);
    endtask

    initial begin
        int b0;
        int cyc;
        for (int c = 0; c < 6; c++) in_v[c] = '0;
        #3;
        check_all_zero("reset");
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: requantisation edge values
        b0 = beats_total;
        drive_frame(1, 1'b0);
        wait_done(cyc);
        check("s1 beats", beats_total - b0, NBEAT);
        check("rq 383", cap[0], 1);
        check("rq 384", cap[1], 2);
        check("rq -5", cap[2], 0);
        check("rq 32639", cap[3], 127);
        check("rq 32640", cap[4], 127);
        check("rq 40000", cap[5], 127);
        check("rq -1", cap[144], 0);
        check("rq 127", cap[145], 0);
        check("rq 128", cap[146], 1);
        check("rq int max", cap[147], 127);

        // 2: full frame, continuous ready
        b0 = beats_total;
        drive_frame(0, 1'b0);
        wait_done(cyc);
        check("s2 drain cycles", cyc + 2, 866);
        check("s2 beats", beats_total - b0, NBEAT);
        check("s2 beat 0", cap[0], 0);
        check("s2 beat 200", cap[200], 72);
        check("s2 beat 863", cap[863], 95);
        check("s2 overflow", overflow, 0);

        // 3: random backpressure
        rdy_mode = 1'b1;
        b0 = beats_total;
        drive_frame(0, 1'b0);
        wait_done(cyc);
        check("s3 beats", beats_total - b0, NBEAT);
        rdy_mode = 1'b0;

        // 4: input beats dropped during replay
        b0 = beats_total;
        drive_frame(0, 1'b0);
        wait_beats(b0 + 100);
        for (int c = 0; c < 6; c++) in_v[c] = 32'h0000_1000;
        valid_in = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        check("s4 overflow set", overflow, 1);
        wait_done(cyc);
        check("s4 beats", beats_total - b0, NBEAT);
        check("s4 overflow held", overflow, 1);
        b0 = beats_total;
        drive_frame(1, 1'b0);
        wait_done(cyc);
        check("s4 next frame beats", beats_total - b0, NBEAT);
        check("s4 next frame rq 384", cap[1], 2);
        check("s4 overflow still held", overflow, 1);

        // 5: asynchronous reset during replay
        b0 = beats_total;
        drive_frame(0, 1'b0);
        wait_beats(b0 + 300);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-drain reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        b0 = beats_total;
        drive_frame(0, 1'b0);
        wait_done(cyc);
        check("s5 beats", beats_total - b0, NBEAT);
        check("s5 drain cycles", cyc + 2, 866);
        check("s5 overflow", overflow, 0);

        // 6: gapped input, 1-in-3 duty
        b0 = beats_total;
        drive_frame(0, 1'b1);
        wait_done(cyc);
        check("s6 beats", beats_total - b0, NBEAT);
        check("s6 beat 500", cap[500], 116);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
